// File: rtl/chunk_serial_adder.sv
// Chunk-serial adder: adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first.
// Define CHUNK_SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module chunk_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CP1    = CHUNK + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CHUNK:0]   chunkSum;
    int               base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        base     = int'(cnt_q) * CHUNK;
        chunkSum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]} + CP1'(carry_q);

        case (state_q)
            RUN: begin
                s_d[base +: CHUNK] = chunkSum[CHUNK-1:0];
                carry_d            = chunkSum[CHUNK];
                cnt_d              = cnt_q + CW'(1);
                // The final chunk's top sum bit is the new s MSB, so overflow is taken from it directly.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    cout_d  = chunkSum[CHUNK];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunkSum[CHUNK-1] != a_q[WIDTH-1]);
                end
            end
            default: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    s_d     = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign cout = cout_q;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`else
    logic unusedOvf;
    assign unusedOvf = ovf_q;
`endif

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder: a 16/4 instance plus a 16/16 instance for back-to-back.
module tb_chunk_serial_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start, cin, busy, done, cout;
    logic [15:0] a, b, s;
    logic        startW, cinW, busyW, doneW, coutW;
    logic [15:0] aW, bW, sW;
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic        ovf, ovfW;
`endif

    int   errors = 0;
    int   checks = 0;
    int   lat, busyCnt, doneSeen;
    exp_t scoreQ[$];
    exp_t scoreQW[$];
    exp_t e;

    chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .s(s),
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        .ovf(ovf),
`endif
        .cout(cout)
    );

    chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) dutW (
        .clk(clk), .rst(rst), .start(startW), .a(aW), .b(bW), .cin(cinW),
        .busy(busyW), .done(doneW), .s(sW),
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        .ovf(ovfW),
`endif
        .cout(coutW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        exp_t        r;
        full   = {1'b0, x} + {1'b0, y} + 17'(c);
        r.s    = full[15:0];
        r.cout = full[16];
        r.ovf  = (x[15] == y[15]) && (full[15] != x[15]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic c);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        scoreQ.push_back(model(x, y, c));
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, then compares against the oldest queued expectation and checks the hold.
    task automatic checkOutput(input string tag, input int expLat);
        exp_t r;
        lat     = 0;
        busyCnt = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busyCnt++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, expLat);
        check({tag, " busy@done"}, busy, 0);
        if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s scoreboard: observed=empty expected=entry", tag);
        end else begin
            r = scoreQ.pop_front();
            check({tag, " s"}, s, r.s);
            check({tag, " cout"}, cout, r.cout);
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
            check({tag, " ovf"}, ovf, r.ovf);
`endif
            tick();
            check({tag, " done pulse"}, done, 0);
            check({tag, " s hold"}, s, r.s);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        startW = 1'b0; aW = '0; bW = '0; cinW = 1'b0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset s", s, 0);
        check("reset cout", cout, 0);
        rst = 1'b0;
        tick();

        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        checkOutput("add_00ff", 4);
        check("add_00ff busy cycles", busyCnt, 4);

        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        checkOutput("ripple", 4);

        applyStimulus(16'h0005, 16'h0003, 1'b0);
        void'(scoreQ.pop_back());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun rst busy", busy, 0);
        check("midrun rst done", done, 0);
        check("midrun rst s", s, 0);
        check("midrun rst cout", cout, 0);
        doneSeen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) doneSeen++;
            tick();
        end
        check("midrun rst no done", doneSeen, 0);

        applyStimulus(16'h1234, 16'h1111, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ignore start", 3);

        a = 16'h0001; b = 16'h0001; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst priority busy", busy, 0);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        checkOutput("pos ovf", 4);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        checkOutput("neg ovf", 4);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            checkOutput("random", 4);
        end

        aW = 16'h0001; bW = 16'h0002; cinW = 1'b0; startW = 1'b1;
        scoreQW.push_back(model(16'h0001, 16'h0002, 1'b0));
        tick();
        check("wide busy", busyW, 1);
        check("wide first done low", doneW, 0);
        aW = 16'h0003; bW = 16'h0004;
        scoreQW.push_back(model(16'h0003, 16'h0004, 1'b0));
        tick();
        check("wide done1", doneW, 1);
        e = scoreQW.pop_front();
        check("wide s1", sW, e.s);
        check("wide cout1", coutW, e.cout);
        tick();
        check("wide b2b done drop", doneW, 0);
        check("wide b2b busy", busyW, 1);
        startW = 1'b0;
        tick();
        check("wide done2", doneW, 1);
        e = scoreQW.pop_front();
        check("wide s2", sW, e.s);
        check("wide cout2", coutW, e.cout);
        tick();
        check("wide done2 pulse", doneW, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
